mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master Wishbone arbiter that shares the single on-chip RAM block between the instruction-fetch and data-access ports of the core. It sits between the core's two bus masters and the RAM slave. It grants the bus to one master at a time with round-robin fairness and holds the grant for the whole cycle. A watchdog errors out any transfer the slave never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width of all three ports
- TIMEOUT, 16, cycles a granted strobe may wait for ack before err is raised (≥2)

Ports (prefix i_ = instruction master, d_ = data master, m_ = shared slave side):
- iClk  in  1  clock; all state updates on rising edge
- iRst  in  1  reset; synchronous, active-high
- i_cyc, i_stb  in  1  instruction master cycle/strobe
- i_addr  in  ADDR_W  instruction address
- i_data_read  out  32  read data to instruction master
- i_ack  out  1  transfer acknowledge
- i_err  out  1  timeout error, one-cycle pulse
- d_cyc, d_stb, d_we  in  1  data master cycle/strobe/write-enable
- d_addr  in  ADDR_W  data address
- d_width  in  2  00 byte, 01 half, 1x word
- d_data_write  in  32  write data
- d_data_read  out  32  read data to data master
- d_ack, d_err  out  1  as for i_
- m_cyc, m_stb, m_we  out  1  to RAM slave
- m_addr  out  ADDR_W  to RAM slave
- m_width  out  2  to RAM slave
- m_data_write  out  32  to RAM slave
- m_data_read  in  32  from RAM slave
- m_ack  in  1  from RAM slave; may be combinational from m_stb
- owner  out  2  registered grant: 00 none, 01 instr, 10 data

## Operation
- Instruction port is read-only: it drives m_we=0 and m_width=2'b10 (word), and m_data_write=0.
- FSM states: IDLE, GNT_I, GNT_D. owner encodes the state.
- IDLE: if exactly one cyc is high, grant that master. If both are high, grant the master that was not granted last (last_gnt register; reset value = instr, so data wins the first tie). Otherwise stay in IDLE.
- GNT_x: the granted master's cyc/stb/we/addr/width/data_write are muxed combinationally to m_*. m_data_read and m_ack are routed to x only. Non-granted master sees ack=0, err=0, data_read=0.
- Release: when the granted master's cyc is low, leave GNT_x and update last_gnt=x in the same edge. If the other master's cyc is high, go directly to its grant state. Otherwise go to IDLE.
- In IDLE, all m_* outputs are 0.
- Watchdog: the wait counter (width clog2(TIMEOUT+1)) clears on m_ack, on grant change, and whenever the granted stb is low. It increments while the granted stb is high and m_ack is low.
  - When it reaches TIMEOUT-1 with still no ack, assert x_err for one cycle. On that cycle m_stb is forced to 0, and the counter clears.
  - The grant is kept until cyc drops.
- x_ack and x_err are never asserted in the same cycle.

## Timing
- Reset: state IDLE, owner=00, last_gnt=instr, counter=0. All outputs 0 except pure pass-through of m_data_read, which is gated to 0.
- Arbitration latency: cyc/stb rising in IDLE at edge N gives grant at edge N+1. m_stb and the ack are visible in cycle N+1 with the combinational RAM, so a single-beat access completes one cycle after request.
- Back-to-back beats inside one held cyc: one per cycle, no bubble.
- Handover: with the other master waiting, the transition takes zero idle cycles. The new owner's stb reaches m_stb in the cycle after the old owner drops cyc.
- A master dropping cyc mid-wait (no ack yet): the grant is released at the next edge, the counter clears, and no err is raised.
- Reset mid-transfer: the next edge returns to IDLE with m_cyc=0. In-flight writes are abandoned; RAM content is untouched by the arbiter.

## Structure
- Shared package mem_pkg: owner encoding (OWN_NONE/OWN_I/OWN_D), width encoding constants (WB_BYTE=2'b00, WB_HALF=2'b01, WB_WORD=2'b10), and the FSM state enum.
- One sub-module, wb_watchdog: parameter TIMEOUT; inputs clear and busy; output a one-cycle expire pulse.

## Test plan
- Single read: after reset, i_cyc=i_stb=1 at addr 0x10 with RAM word 0xDEADBEEF → owner=01 next cycle, i_ack=1 and i_data_read=0xDEADBEEF that cycle; d_ack stays 0.
- Simultaneous request: i and d raise cyc on the same edge → d granted first (last_gnt=instr at reset). When d drops cyc, i is granted on the next edge with no IDLE cycle.
- Round-robin: both masters keep re-requesting for 6 grants → owner sequence is 10,01,10,01,10,01.
- Data write, half-word: d_we=1, d_width=01, addr 0x20, data 0x0000A55A → m_width=01, m_data_write passes through. A subsequent i read of 0x20 returns 0x????A55A in the low half.
- Timeout: slave ack tied low, TIMEOUT=16, d_stb held → d_err pulses exactly once, 16 cycles after the grant. m_stb=0 on that cycle, owner stays 10 until d_cyc drops.
- Reset mid-transfer: iRst=1 while owner=10 with stb high → next edge owner=00, m_cyc=0, all acks/errs 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-master RAM arbiter: grant owner codes,
// Wishbone transfer widths and the arbiter FSM state.
package mem_pkg;
   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_I    = 2'b01;
   localparam logic [1:0] OWN_D    = 2'b10;

   localparam logic [1:0] WB_BYTE  = 2'b00;
   localparam logic [1:0] WB_HALF  = 2'b01;
   localparam logic [1:0] WB_WORD  = 2'b10;

   // State values equal the owner codes so the state flop drives owner directly.
   typedef enum logic [1:0] {
      ST_IDLE  = OWN_NONE,
      ST_GNT_I = OWN_I,
      ST_GNT_D = OWN_D
   } state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Wishbone classic port with width/byte-size extension; master drives the
// request side, slave returns data/ack/err.
interface mem_arbiter_if #(parameter int ADDR_W = 32);
   logic              cyc;
   logic              stb;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        width;
   logic [31:0]       data_write;
   logic [31:0]       data_read;
   logic              ack;
   logic              err;

   modport master (output cyc, stb, we, addr, width, data_write,
                   input  data_read, ack, err);
   modport slave  (input  cyc, stb, we, addr, width, data_write,
                   output data_read, ack, err);
endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Ack-wait watchdog: counts cycles a granted strobe waits and pulses expire
// once the limit is reached without an acknowledge.
module wb_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic iClk,
   input  logic iRst,
   input  logic clear,
   input  logic busy,
   output logic limit,
   output logic expire
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // limit is independent of clear so the strobe gate can use it without
   // forming a loop through a combinational slave ack.
   assign limit  = busy && (cnt == CW'(TIMEOUT - 1));
   assign expire = limit && !clear;

   always_ff @(posedge iClk) begin
      if (iRst || clear || expire)
         cnt <= '0;
      else if (busy)
         cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM slave between the instruction-fetch
// and data ports; grant is held for the whole cycle, stalls time out.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic           iClk,
   input  logic           iRst,
   mem_arbiter_if.slave   i,
   mem_arbiter_if.slave   d,
   mem_arbiter_if.master  m,
   output logic [1:0]     owner
);
   state_t state, state_nxt;
   logic   last_d;
   logic   stb_g, ack_g;
   logic   wd_clear, wd_limit, wd_expire;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state  <= ST_IDLE;
         last_d <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_GNT_I && !i.cyc)
            last_d <= 1'b0;
         else if (state == ST_GNT_D && !d.cyc)
            last_d <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (i.cyc && d.cyc)
               state_nxt = last_d ? ST_GNT_I : ST_GNT_D;
            else if (i.cyc)
               state_nxt = ST_GNT_I;
            else if (d.cyc)
               state_nxt = ST_GNT_D;
         end
         ST_GNT_I: if (!i.cyc) state_nxt = d.cyc ? ST_GNT_D : ST_IDLE;
         ST_GNT_D: if (!d.cyc) state_nxt = i.cyc ? ST_GNT_I : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Request mux; the instruction port is a fixed word read.
   always_comb begin
      m.cyc        = 1'b0;
      m.stb        = 1'b0;
      m.we         = 1'b0;
      m.addr       = {ADDR_W{1'b0}};
      m.width      = WB_BYTE;
      m.data_write = 32'h0;
      case (state)
         ST_GNT_I: begin
            m.cyc   = i.cyc;
            m.stb   = i.stb && !wd_limit;
            m.addr  = i.addr;
            m.width = WB_WORD;
         end
         ST_GNT_D: begin
            m.cyc        = d.cyc;
            m.stb        = d.stb && !wd_limit;
            m.we         = d.we;
            m.addr       = d.addr;
            m.width      = d.width;
            m.data_write = d.data_write;
         end
         default: ;
      endcase
   end

   assign owner = state;

   assign stb_g = (state == ST_GNT_I) ? i.stb :
                  (state == ST_GNT_D) ? d.stb : 1'b0;
   assign ack_g = (state != ST_IDLE) && m.ack;

   assign i.ack       = (state == ST_GNT_I) && m.ack;
   assign d.ack       = (state == ST_GNT_D) && m.ack;
   assign i.err       = (state == ST_GNT_I) && wd_expire;
   assign d.err       = (state == ST_GNT_D) && wd_expire;
   assign i.data_read = (state == ST_GNT_I) ? m.data_read : 32'h0;
   assign d.data_read = (state == ST_GNT_D) ? m.data_read : 32'h0;

   assign wd_clear = ack_g || !stb_g || (state_nxt != state);

   wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .iClk   (iClk),
      .iRst   (iRst),
      .clear  (wd_clear),
      .busy   (stb_g),
      .limit  (wd_limit),
      .expire (wd_expire)
   );

   // Inputs the fixed-function instruction port and RAM side never use.
   logic unused;
   assign unused = ^{i.we, i.width, i.data_write, m.err};
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a combinational RAM model and a
// read-data scoreboard.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        ack_en;
   logic [1:0]  owner;
   logic [31:0] mem [0:63];
   logic [31:0] exp_q [$];
   logic [31:0] exp_v;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(32)) ib ();
   mem_arbiter_if #(.ADDR_W(32)) db ();
   mem_arbiter_if #(.ADDR_W(32)) mb ();

   mem_arbiter #(.ADDR_W(32), .TIMEOUT(TO)) dut (
      .iClk  (clk),
      .iRst  (rst),
      .i     (ib),
      .d     (db),
      .m     (mb),
      .owner (owner)
   );

   assign ib.we         = 1'b0;
   assign ib.width      = WB_WORD;
   assign ib.data_write = 32'h0;
   assign mb.data_read  = mem[mb.addr[7:2]];
   assign mb.ack        = mb.cyc && mb.stb && ack_en;
   assign mb.err        = 1'b0;

   // RAM model: preloaded while reset is high, byte-lane writes on ack.
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 64; k++)
            mem[k] <= (k == 4) ? 32'hDEADBEEF : (k == 8) ? 32'h11112222 : {16'hC0DE, 16'(k)};
      end else if (mb.ack && mb.we) begin
         case (mb.width)
            WB_BYTE: mem[mb.addr[7:2]][8*mb.addr[1:0] +: 8] <= mb.data_write[8*mb.addr[1:0] +: 8];
            WB_HALF: mem[mb.addr[7:2]][16*mb.addr[1] +: 16] <= mb.data_write[16*mb.addr[1] +: 16];
            default: mem[mb.addr[7:2]] <= mb.data_write;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_all();
      ib.cyc = 1'b0; ib.stb = 1'b0;
      db.cyc = 1'b0; db.stb = 1'b0; db.we = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      checks++; if (owner !== OWN_NONE) begin errors++; $display("FAIL reset_owner: got %b want 00", owner); end
      checks++; if ({mb.cyc, mb.stb, mb.we} !== 3'b000) begin errors++; $display("FAIL reset_mbus: got %b want 000", {mb.cyc, mb.stb, mb.we}); end
      checks++; if ({ib.ack, ib.err, db.ack, db.err} !== 4'b0000) begin errors++; $display("FAIL reset_resp: got %b want 0000", {ib.ack, ib.err, db.ack, db.err}); end
      checks++; if ({ib.data_read, db.data_read} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {ib.data_read, db.data_read}); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      tick();
      ib.cyc = 1'b1; ib.stb = 1'b1; ib.addr = 32'h10;
      exp_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      checks++; if (owner !== OWN_NONE) begin errors++; $display("FAIL read_pregrant: got %b want 00", owner); end
      tick();
      @(negedge clk);
      checks++; if (owner !== OWN_I) begin errors++; $display("FAIL read_owner: got %b want 01", owner); end
      checks++; if (ib.ack !== 1'b1 || db.ack !== 1'b0) begin errors++; $display("FAIL read_ack: got i=%b d=%b want i=1 d=0", ib.ack, db.ack); end
      checks++; if (mb.we !== 1'b0 || mb.width !== WB_WORD) begin errors++; $display("FAIL read_we_width: got %b/%b want 0/10", mb.we, mb.width); end
      exp_v = exp_q.pop_front();
      checks++; if (ib.data_read !== exp_v) begin errors++; $display("FAIL read_data: got %h want %h", ib.data_read, exp_v); end
      tick();
      drop_all();
      tick();
      @(negedge clk);
      checks++; if (owner !== OWN_NONE) begin errors++; $display("FAIL read_release: got %b want 00", owner); end
   endtask

   task automatic test_write_half();
      db.cyc = 1'b1; db.stb = 1'b1; db.we = 1'b1; db.width = WB_HALF;
      db.addr = 32'h20; db.data_write = 32'h0000A55A;
      tick();
      @(negedge clk);
      checks++; if (owner !== OWN_D || db.ack !== 1'b1 || ib.ack !== 1'b0) begin errors++; $display("FAIL wr_grant: got own=%b dack=%b iack=%b want 10/1/0", owner, db.ack, ib.ack); end
      checks++; if ({mb.we, mb.width} !== 3'b101) begin errors++; $display("FAIL wr_we_width: got %b want 101", {mb.we, mb.width}); end
      checks++; if (mb.data_write !== 32'h0000A55A || mb.addr !== 32'h20) begin errors++; $display("FAIL wr_pass: got %h@%h want 0000a55a@20", mb.data_write, mb.addr); end
      tick();
      drop_all();
      tick();
      ib.cyc = 1'b1; ib.stb = 1'b1; ib.addr = 32'h20;
      exp_q.push_back(32'h1111A55A);
      tick();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++; if (ib.ack !== 1'b1 || ib.data_read !== exp_v) begin errors++; $display("FAIL wr_readback: got ack=%b %h want 1 %h", ib.ack, ib.data_read, exp_v); end
      tick();
      drop_all();
      tick();
   endtask

   task automatic test_back_to_back();
      db.cyc = 1'b1; db.stb = 1'b1; db.we = 1'b1; db.width = WB_WORD;
      db.addr = 32'h30; db.data_write = 32'hCAFE0000;
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if (owner !== OWN_D || db.ack !== 1'b1) begin errors++; $display("FAIL b2b_wr%0d: got own=%b ack=%b want 10/1", k, owner, db.ack); end
         tick();
         if (k < 3) begin
            db.addr = 32'h30 + 32'(4 * (k + 1));
            db.data_write = 32'hCAFE0000 | 32'(k + 1);
         end
      end
      // Data drops while instruction requests: direct handover.
      drop_all();
      ib.cyc = 1'b1; ib.stb = 1'b1; ib.addr = 32'h30;
      exp_q.push_back(32'hCAFE0000);
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exp_v = exp_q.pop_front();
         checks++; if (owner !== OWN_I || ib.ack !== 1'b1 || ib.data_read !== exp_v) begin errors++; $display("FAIL b2b_rd%0d: got own=%b ack=%b %h want 01/1 %h", k, owner, ib.ack, ib.data_read, exp_v); end
         tick();
         if (k < 3) begin
            ib.addr = 32'h30 + 32'(4 * (k + 1));
            exp_q.push_back(32'hCAFE0000 | 32'(k + 1));
         end
      end
      drop_all();
      tick();
   endtask

   task automatic test_simultaneous();
      pulse_reset();
      ib.cyc = 1'b1; ib.stb = 1'b1; ib.addr = 32'h10;
      db.cyc = 1'b1; db.stb = 1'b1; db.we = 1'b0; db.width = WB_WORD; db.addr = 32'h20;
      exp_q.push_back(32'h11112222);
      tick();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++; if (owner !== OWN_D || db.ack !== 1'b1 || ib.ack !== 1'b0) begin errors++; $display("FAIL sim_first: got own=%b dack=%b iack=%b want 10/1/0", owner, db.ack, ib.ack); end
      checks++; if (db.data_read !== exp_v) begin errors++; $display("FAIL sim_ddata: got %h want %h", db.data_read, exp_v); end
      tick();
      @(negedge clk);
      checks++; if (ib.ack !== 1'b0 || ib.data_read !== 32'h0) begin errors++; $display("FAIL sim_iwait: got ack=%b %h want 0 0", ib.ack, ib.data_read); end
      tick();
      db.cyc = 1'b0; db.stb = 1'b0;
      exp_q.push_back(32'hDEADBEEF);
      tick();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++; if (owner !== OWN_I) begin errors++; $display("FAIL sim_handover: got %b want 01", owner); end
      checks++; if (mb.stb !== 1'b1 || mb.addr !== 32'h10) begin errors++; $display("FAIL sim_mstb: got %b@%h want 1@10", mb.stb, mb.addr); end
      checks++; if (ib.ack !== 1'b1 || ib.data_read !== exp_v) begin errors++; $display("FAIL sim_idata: got ack=%b %h want 1 %h", ib.ack, ib.data_read, exp_v); end
      tick();
      drop_all();
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] want;
      pulse_reset();
      ib.cyc = 1'b1; ib.stb = 1'b1; ib.addr = 32'h10;
      db.cyc = 1'b1; db.stb = 1'b1; db.we = 1'b0; db.addr = 32'h20;
      tick();
      for (int k = 0; k < 6; k++) begin
         want = (k % 2 == 0) ? OWN_D : OWN_I;
         @(negedge clk);
         checks++; if (owner !== want) begin errors++; $display("FAIL rr_owner%0d: got %b want %b", k, owner, want); end
         checks++; if ({db.ack, ib.ack} !== want) begin errors++; $display("FAIL rr_ack%0d: got d=%b i=%b want %b", k, db.ack, ib.ack, want); end
         tick();
         if (want == OWN_D) begin db.cyc = 1'b0; db.stb = 1'b0; end
         else               begin ib.cyc = 1'b0; ib.stb = 1'b0; end
         tick();
         if (want == OWN_D) begin db.cyc = 1'b1; db.stb = 1'b1; end
         else               begin ib.cyc = 1'b1; ib.stb = 1'b1; end
      end
      drop_all();
      tick();
      tick();
   endtask

   task automatic test_timeout();
      int errs, err_at;
      logic own_ok, ack_seen;
      errs = 0; err_at = -1; own_ok = 1'b1; ack_seen = 1'b0;
      ack_en = 1'b0;
      db.cyc = 1'b1; db.stb = 1'b1; db.we = 1'b0; db.addr = 32'h40;
      tick();
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (owner !== OWN_D) own_ok = 1'b0;
         if (db.ack !== 1'b0) ack_seen = 1'b1;
         if (db.err === 1'b1) begin
            errs++;
            err_at = c;
            checks++; if (mb.stb !== 1'b0 || mb.cyc !== 1'b1) begin errors++; $display("FAIL to_mstb: got stb=%b cyc=%b want 0/1", mb.stb, mb.cyc); end
         end
      end
      checks++; if (errs != 1 || err_at != TO) begin errors++; $display("FAIL to_pulse: got %0d pulses at %0d want 1 at %0d", errs, err_at, TO); end
      checks++; if (!own_ok || ack_seen) begin errors++; $display("FAIL to_hold: got own_ok=%b ack=%b want 1/0", own_ok, ack_seen); end
      tick();
      drop_all();
      tick();
      @(negedge clk);
      checks++; if (owner !== OWN_NONE || db.err !== 1'b0) begin errors++; $display("FAIL to_release: got own=%b err=%b want 00/0", owner, db.err); end
      ack_en = 1'b1;
   endtask

   task automatic test_drop_midwait();
      int errs, err_at;
      logic any_err;
      any_err = 1'b0; errs = 0; err_at = -1;
      ack_en = 1'b0;
      ib.cyc = 1'b1; ib.stb = 1'b1; ib.addr = 32'h44;
      tick();
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (ib.err !== 1'b0) any_err = 1'b1;
      end
      tick();
      drop_all();
      tick();
      @(negedge clk);
      if (ib.err !== 1'b0) any_err = 1'b1;
      checks++; if (owner !== OWN_NONE || any_err) begin errors++; $display("FAIL drop_release: got own=%b err=%b want 00/0", owner, any_err); end
      ib.cyc = 1'b1; ib.stb = 1'b1;
      tick();
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (ib.err === 1'b1) begin errs++; if (err_at < 0) err_at = c; end
      end
      checks++; if (errs != 1 || err_at != TO) begin errors++; $display("FAIL drop_restart: got %0d pulses first at %0d want 1 at %0d", errs, err_at, TO); end
      tick();
      drop_all();
      tick();
      ack_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      ack_en = 1'b0;
      db.cyc = 1'b1; db.stb = 1'b1; db.we = 1'b1; db.width = WB_WORD;
      db.addr = 32'h50; db.data_write = 32'h12345678;
      tick();
      @(negedge clk);
      checks++; if (owner !== OWN_D || mb.stb !== 1'b1) begin errors++; $display("FAIL rstm_pre: got own=%b stb=%b want 10/1", owner, mb.stb); end
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      checks++; if (owner !== OWN_NONE || mb.cyc !== 1'b0) begin errors++; $display("FAIL rstm_state: got own=%b cyc=%b want 00/0", owner, mb.cyc); end
      checks++; if ({ib.ack, ib.err, db.ack, db.err} !== 4'b0000) begin errors++; $display("FAIL rstm_resp: got %b want 0000", {ib.ack, ib.err, db.ack, db.err}); end
      drop_all();
      tick();
      rst = 1'b0;
      ack_en = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1; ack_en = 1'b1;
      ib.cyc = 1'b0; ib.stb = 1'b0; ib.addr = 32'h0;
      db.cyc = 1'b0; db.stb = 1'b0; db.we = 1'b0; db.addr = 32'h0;
      db.width = WB_WORD; db.data_write = 32'h0;
      test_reset();
      test_single_read();
      test_write_half();
      test_back_to_back();
      test_simultaneous();
      test_round_robin();
      test_timeout();
      test_drop_midwait();
      test_reset_mid();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
